// File: rtl/llr_bram_mp_if.sv
// Bundle of the LLR memory write port, NR read ports and status flags.
interface llr_bram_mp_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 12,
  parameter int LANES      = 2,
  parameter int NR         = 2
);
  logic                       busy;
  logic                       we;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [LANES-1:0]           wr_mask;
  logic [DATA_WIDTH-1:0]      din;
  logic [NR-1:0]              re;
  logic [NR*ADDR_WIDTH-1:0]   rd_addr;
  logic [NR*DATA_WIDTH-1:0]   dout;
  logic [NR-1:0]              dout_valid;

  modport master (
    output we, wr_addr, wr_mask, din, re, rd_addr,
    input  busy, dout, dout_valid
  );

  modport slave (
    input  we, wr_addr, wr_mask, din, re, rd_addr,
    output busy, dout, dout_valid
  );
endinterface

// File: rtl/llr_bram_mp.sv
// Replicated-bank LLR memory: 1 masked write port, NR write-first read ports.
// Read latency 1+OUT_REG; no backpressure, every request is dropped while busy.
module llr_bram_mp #(
  parameter int n            = 5,
  parameter int p            = 1,
  parameter int Q            = 6,
  parameter int NR           = 2,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1,
  localparam int LANES       = 2**p,
  localparam int DATA_WIDTH  = LANES*Q,
  localparam int DEPTH       = 2**(n-p)-2+p,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  llr_bram_mp_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH-1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  idle;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] lane_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == LAST)
        state <= ST_IDLE;
    end
  end

  assign idle     = (state == ST_IDLE) && !rst;
  assign bus.busy = (state == ST_CLEAR);
  assign wr_ok    = idle && bus.we && ({1'b0, bus.wr_addr} < DEPTH_W);

  always_comb begin
    lane_en = '0;
    for (int k = 0; k < LANES; k++)
      lane_en[k*Q +: Q] = {Q{bus.wr_mask[k]}};
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ra;
    logic                  ra_ok;
    logic                  rd_go;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] s1_dat;
    logic                  s1_vld;

    assign ra    = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign ra_ok = ({1'b0, ra} < DEPTH_W);
    assign rd_go = idle && bus.re[gi];

    // Every bank sees the same clear sweep and writes, so all stay identical.
    always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok) begin
        for (int k = 0; k < LANES; k++)
          if (bus.wr_mask[k])
            mem[bus.wr_addr][k*Q +: Q] <= bus.din[k*Q +: Q];
      end
    end

    // Write-first: merge same-cycle write lanes over the stored word.
    always_comb begin
      rdata = '0;
      if (ra_ok) begin
        rdata = mem[ra];
        if (wr_ok && (ra == bus.wr_addr))
          rdata = (rdata & ~lane_en) | (bus.din & lane_en);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_dat <= '0;
        s1_vld <= 1'b0;
      end else begin
        s1_dat <= rd_go ? rdata : '0;
        s1_vld <= rd_go;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] s2_dat;
      logic                  s2_vld;
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_dat <= '0;
          s2_vld <= 1'b0;
        end else begin
          s2_dat <= s1_dat;
          s2_vld <= s1_vld;
        end
      end
      assign bus.dout[gi*DATA_WIDTH +: DATA_WIDTH] = s2_dat;
      assign bus.dout_valid[gi]                    = s2_vld;
    end else begin : g_noreg
      assign bus.dout[gi*DATA_WIDTH +: DATA_WIDTH] = s1_dat;
      assign bus.dout_valid[gi]                    = s1_vld;
    end
  end

endmodule

// File: tb/tb_llr_bram_mp.sv
// Directed bench: OUT_REG=0 and OUT_REG=1 instances driven with identical stimulus.
module tb_llr_bram_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  llr_bram_mp_if #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .LANES(2), .NR(2)) i0 ();
  llr_bram_mp_if #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .LANES(2), .NR(2)) i1 ();

  assign i1.we      = i0.we;
  assign i1.wr_addr = i0.wr_addr;
  assign i1.wr_mask = i0.wr_mask;
  assign i1.din     = i0.din;
  assign i1.re      = i0.re;
  assign i1.rd_addr = i0.rd_addr;

  llr_bram_mp #(.n(5), .p(1), .Q(6), .NR(2), .OUT_REG(0), .CLEAR_ON_RST(1))
    dut0 (.clk(clk), .rst(rst), .bus(i0));
  llr_bram_mp #(.n(5), .p(1), .Q(6), .NR(2), .OUT_REG(1), .CLEAR_ON_RST(1))
    dut1 (.clk(clk), .rst(rst), .bus(i1));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [1:0]  wm;
    logic [11:0] din;
    logic [1:0]  re;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [11:0] d0;
    logic        v0;
    logic [11:0] d1;
    logic        v1;
  } vec_t;

  vec_t tv[$];
  vec_t prev;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [1:0] wm, logic [11:0] din,
                              logic [1:0] re, logic [3:0] ra0, logic [3:0] ra1,
                              logic [11:0] d0, logic v0, logic [11:0] d1, logic v1);
    vec_t v;
    v.we = we; v.wa = wa; v.wm = wm; v.din = din; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i0.we      = v.we;
    i0.wr_addr = v.wa;
    i0.wr_mask = v.wm;
    i0.din     = v.din;
    i0.re      = v.re;
    i0.rd_addr = {v.ra1, v.ra0};
  endtask

  task automatic idle_in();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Counts edges until busy drops; outputs must stay quiet throughout.
  task automatic wait_clear(input string nm);
    int cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      chk({nm, "_dout0"}, 32'(i0.dout), 0);
      chk({nm, "_vld0"},  32'(i0.dout_valid), 0);
      chk({nm, "_dout1"}, 32'(i1.dout), 0);
      chk({nm, "_vld1"},  32'(i1.dout_valid), 0);
    end while (i0.busy && cnt < 40);
    chk({nm, "_len"}, 32'(cnt), 15);
    chk({nm, "_busy1"}, 32'(i1.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 15; a++)
      tv.push_back(mk(0, 0, 0, 0, 2'b11, 4'(a), 4'(14 - a), 0, 1, 0, 1));
    tv.push_back(mk(1, 3, 2'b11, 12'hABC, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 2'b01, 3, 0, 12'hABC, 1, 0, 0));
    tv.push_back(mk(1, 5, 2'b11, 12'h111, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 5, 2'b10, 12'hFEC, 2'b11, 5, 5, 12'hFD1, 1, 12'hFD1, 1));
    tv.push_back(mk(0, 0, 0, 0, 2'b11, 5, 3, 12'hFD1, 1, 12'hABC, 1));
    tv.push_back(mk(1, 15, 2'b11, 12'hFFF, 2'b11, 15, 14, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 2'b11, 0, 7, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 2'b11, 1, 2, 0, 1, 0, 1));
    tv.push_back(mk(1, 7, 2'b01, 12'h0C3, 2'b10, 0, 7, 0, 0, 12'h003, 1));
    tv.push_back(mk(0, 0, 0, 0, 2'b01, 3, 0, 12'hABC, 1, 0, 0));
    for (int k = 0; k < 10; k++)
      tv.push_back(mk(0, 0, 0, 0, 2'b01, (k % 2) ? 4'd5 : 4'd3, 0,
                      (k % 2) ? 12'hFD1 : 12'hABC, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 2'b01, 3, 0, 12'hABC, 1, 0, 0));
    tv.push_back(mk(1, 3, 2'b11, 12'h123, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 2'b11, 3, 7, 12'h123, 1, 12'h003, 1));
    tv.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", 32'(i0.busy), 1);
    chk("rst_busy1", 32'(i1.busy), 1);
    chk("rst_dout0", 32'(i0.dout), 0);
    chk("rst_vld0",  32'(i0.dout_valid), 0);
    chk("rst_dout1", 32'(i1.dout), 0);
    chk("rst_vld1",  32'(i1.dout_valid), 0);

    rst = 1'b0;
    drive(mk(1, 7, 2'b11, 12'hFFF, 2'b11, 7, 7, 0, 0, 0, 0));
    wait_clear("clear");

    prev = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < tv.size(); j++) begin
      drive(tv[j]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_d0", j),   32'(i0.dout[11:0]),   32'(tv[j].d0));
      chk($sformatf("v%0d_v0", j),   32'(i0.dout_valid[0]), 32'(tv[j].v0));
      chk($sformatf("v%0d_d1", j),   32'(i0.dout[23:12]),  32'(tv[j].d1));
      chk($sformatf("v%0d_v1", j),   32'(i0.dout_valid[1]), 32'(tv[j].v1));
      chk($sformatf("v%0d_r_d0", j), 32'(i1.dout[11:0]),   32'(prev.d0));
      chk($sformatf("v%0d_r_v0", j), 32'(i1.dout_valid[0]), 32'(prev.v0));
      chk($sformatf("v%0d_r_d1", j), 32'(i1.dout[23:12]),  32'(prev.d1));
      chk($sformatf("v%0d_r_v1", j), 32'(i1.dout_valid[1]), 32'(prev.v1));
      prev = tv[j];
    end

    drive(mk(1, 7, 2'b11, 12'h5A5, 2'b00, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 2'b01, 7, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("mid_pre_d0", 32'(i0.dout[11:0]), 32'h5A5);
    idle_in();
    @(posedge clk); #1;
    chk("mid_pre_r_d0", 32'(i1.dout[11:0]), 32'h5A5);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", 32'(i0.busy), 1);
    rst = 1'b1;
    drive(mk(1, 7, 2'b11, 12'hFFF, 2'b11, 7, 7, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("mid_rst_vld", 32'(i0.dout_valid), 0);
    rst = 1'b0;
    wait_clear("reclear");

    drive(mk(0, 0, 0, 0, 2'b11, 7, 7, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("mid_post_dout", 32'(i0.dout), 0);
    chk("mid_post_vld",  32'(i0.dout_valid), 3);
    idle_in();
    @(posedge clk); #1;
    chk("mid_post_r_dout", 32'(i1.dout), 0);
    chk("mid_post_r_vld",  32'(i1.dout_valid), 3);
    chk("mid_post_idle_vld", 32'(i0.dout_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/llr_bram_mp.md
# llr_bram_mp

Parametrised LLR storage for the successive-cancellation decoder datapath: one write port with per-lane write mask and NR independent read ports, built from replicated block-RAM banks (one bank per read port, all written identically). Successor to the two-read-port LLR memory. Adds synchronous reset with a hardware clear sweep, write-first collision bypass, selectable read latency, per-port valid flags and out-of-range protection. Sits between the LLR update units and the f/g processing elements.

## Interface
- n, 5: log2 code length
- p, 1: log2 processing-element parallelism; 2^p lanes per word
- Q, 6: bits per LLR lane
- NR, 2: number of read ports (≥1)
- OUT_REG, 0: 1 adds an output register stage; read latency L = 1 + OUT_REG
- CLEAR_ON_RST, 1: 1 zeroes the whole array after reset
- Derived: DATA_WIDTH = 2^p·Q; DEPTH = 2^(n-p)-2+p; ADDR_WIDTH = $clog2(DEPTH)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- busy  out  1  clear sweep in progress; all requests ignored
- we  in  1  write enable
- wr_addr  in  ADDR_WIDTH  write address
- wr_mask  in  2^p  lane enables; lane k = din[k·Q +: Q]
- din  in  DATA_WIDTH  write data
- re  in  NR  per-port read enable
- rd_addr  in  NR·ADDR_WIDTH  port i address = rd_addr[i·ADDR_WIDTH +: ADDR_WIDTH]
- dout  out  NR·DATA_WIDTH  port i data = dout[i·DATA_WIDTH +: DATA_WIDTH]
- dout_valid  out  NR  port i data valid

## Operation
- FSM states: CLEAR, IDLE. rst=1 → CLEAR with clr_addr=0 (or IDLE if CLEAR_ON_RST=0). In CLEAR each cycle writes all-zero to clr_addr in every bank and increments it. When clr_addr=DEPTH-1 the write is done and the next state is IDLE. busy=1 exactly when the state is CLEAR.
- rst during CLEAR restarts the sweep at address 0. rst during IDLE drops all in-flight reads.
- While busy: we and re ignored; dout=0, dout_valid=0.
- Write in IDLE: for each lane k with wr_mask[k]=1, lane k of RAM[wr_addr] ← din lane k. Other lanes are preserved. Each lane is a Q-bit read-modify-write or byte-enable-style write; the implementation chooses which, and results are identical.
- wr_addr ≥ DEPTH: the write is dropped entirely.
- Read on port i in IDLE with re[i]=1: returns the word as it stands after any same-cycle write has been applied (write-first).
  - If rd_addr_i = wr_addr, we=1 and the address is in range, masked lanes come from din and unmasked lanes from stored data.
  - Bypass applies independently to every port.
- Read with re[i]=1 and address ≥ DEPTH: dout_valid asserted, data all-zero.
- re[i]=0: that port outputs zero data and valid 0 L cycles later. There is no hold of the previous value.
- Ports are fully independent. Any ports may read the same address in the same cycle.
- With CLEAR_ON_RST=0: busy stays 0 and array contents after reset are undefined; reset still clears the output and pipeline registers.

## Timing
- Reset values: dout=0, dout_valid=0, all pipeline stages zero/invalid, busy=1 if CLEAR_ON_RST else 0.
- Clear duration: busy stays high while rst=1 and for exactly DEPTH cycles after the first clk edge with rst=0. The first request is accepted on cycle DEPTH+1.
- Read latency L: a request sampled at edge t yields dout/dout_valid updated at edge t+L. Throughput is 1 read per port per cycle, with no bubbles.
- Write latency: data written at edge t is visible to a read sampled at edge t (bypass) and at every later edge.
- With OUT_REG=1, a write at t+1 to an address read at t does not alter the value delivered at t+2.

## Test plan
Configuration for all scenarios: n=5, p=1, Q=6, NR=2, giving DATA_WIDTH=12, DEPTH=15, ADDR_WIDTH=4.
- Reset/clear: pulse rst for 2 cycles → busy high for 15 cycles after release. Then reading addresses 0..14 on both ports returns 12'h000 with valid=1. busy falls on the 15th edge.
- Basic write/read (OUT_REG=0): write 12'hABC to addr 3 with mask 2'b11. Next cycle set re=2'b01, rd_addr port0=3 → one cycle later dout0=12'hABC, valid0=1, dout1=0, valid1=0.
- Masked collision bypass: addr 5 holds 12'h111. In the same cycle drive we=1, wr_addr=5, din=12'hFEC, wr_mask=2'b10, and read addr 5 on both ports → both ports return 12'hFD1. A later read of addr 5 also returns 12'hFD1.
- Out-of-range: write 12'hFFF to addr 15, then read addr 15 → dout=0, valid=1. Addresses 0..14 are unchanged.
- Reset mid-operation: write 12'h5A5 to addr 7, then assert rst at sweep count 6 during a second clear. Assert we for addr 7 during busy → busy restarts a full 15-cycle count. Afterwards addr 7 reads 12'h000.
- OUT_REG=1 streaming: issue 10 back-to-back reads alternating addr 3/5 on port 0 → outputs appear 2 cycles later with valid high for 10 consecutive cycles and data alternating correctly.
